// File: rtl/mem_wait_pkg.sv
// Shared types and constants for the wait-state memory controller.
// Build option: MEM_TIMEOUT_EN enables the WAIT watchdog.
package mem_wait_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [31:0] MEM_ABORT_DATA = 32'hDEADBEEF;
  localparam int TIMEOUT_CYC_DEF = 16;

endpackage

// File: rtl/mem_wait_ctrl_if.sv
// CPU-side and memory-side signals of the wait-state controller.
// master: the controller; slave: the CPU/memory environment.
interface mem_wait_ctrl_if #(
  parameter int ADDR_W = 8
);

  logic [31:0]       cpu_adr;
  logic [31:0]       cpu_wdata;
  logic              cpu_re;
  logic              cpu_we;
  logic [31:0]       cpu_rdata;
  logic              cpu_stall;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;
  logic              err;

  modport master (
    input  cpu_adr,
    input  cpu_wdata,
    input  cpu_re,
    input  cpu_we,
    output cpu_rdata,
    output cpu_stall,
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_ack,
    input  mem_rdata,
    output err
  );

  modport slave (
    output cpu_adr,
    output cpu_wdata,
    output cpu_re,
    output cpu_we,
    input  cpu_rdata,
    input  cpu_stall,
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_ack,
    output mem_rdata,
    input  err
  );

endinterface

// File: rtl/mem_wd_cnt.sv
// Watchdog counter for the WAIT state of mem_wait_ctrl.
// Instantiated only when MEM_TIMEOUT_EN is defined.
module mem_wd_cnt
  import mem_wait_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYC + 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Fires during the last allowed WAIT cycle without ack.
  assign expired = (cnt_q == W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_wait_ctrl.sv
// Stalls the datapath around a req/ack handshake memory access.
// Build option: MEM_TIMEOUT_EN adds a WAIT watchdog and sticky err.
module mem_wait_ctrl
  import mem_wait_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input logic             clk,
  input logic             rst_n,
  mem_wait_ctrl_if.master bus
);

  state_e            state_q;
  state_e            state_d;
  logic              we_q;
  logic              we_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic [31:0]       wdata_q;
  logic [31:0]       wdata_d;
  logic [31:0]       rdata_q;
  logic [31:0]       rdata_d;
  logic              stall;
  logic              req;
  logic              cpu_req;

  logic unused_adr;
  assign unused_adr = ^{bus.cpu_adr[31:ADDR_W+2], bus.cpu_adr[1:0]};

  assign cpu_req = bus.cpu_re | bus.cpu_we;

`ifdef MEM_TIMEOUT_EN
  logic err_q;
  logic err_d;
  logic cnt_clr;
  logic cnt_en;
  logic expired;

  mem_wd_cnt #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wd (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .expired(expired)
  );
`endif

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    stall   = 1'b0;
    req     = 1'b0;
`ifdef MEM_TIMEOUT_EN
    err_d   = err_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          stall   = 1'b1;
          we_d    = bus.cpu_we;
          addr_d  = bus.cpu_adr[ADDR_W+1:2];
          wdata_d = bus.cpu_wdata;
          state_d = S_WAIT;
`ifdef MEM_TIMEOUT_EN
          cnt_clr = 1'b1;
`endif
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        req   = 1'b1;
        // An ack in the expiry cycle takes priority over the abort.
        if (bus.mem_ack) begin
          if (!we_q) begin
            rdata_d = bus.mem_rdata;
          end
          state_d = S_DONE;
        end
`ifdef MEM_TIMEOUT_EN
        else begin
          cnt_en = 1'b1;
          if (expired) begin
            if (!we_q) begin
              rdata_d = MEM_ABORT_DATA;
            end
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.cpu_stall = stall;
  assign bus.cpu_rdata = rdata_q;
  assign bus.mem_req   = req;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

endmodule

// File: doc/mem_wait_ctrl.md
MEM_WAIT_CTRL -- requirements
Module: mem_wait_ctrl

Interface
REQ-001 Parameter ADDR_W, default 8, is the memory word-address width.
REQ-002 Parameter TIMEOUT_CYC, default 16, is the number of WAIT cycles allowed before abort (only used when MEM_TIMEOUT_EN is defined).
REQ-003 Port clk  input  1  is the single clock; all state changes on its rising edge.
REQ-004 Port rst_n  input  1  is the asynchronous, active-low reset.
REQ-005 Port cpu_adr  input  32  is the datapath byte address.
REQ-006 Port cpu_wdata  input  32  is the store data.
REQ-007 Port cpu_re / cpu_we  input  1 each  are the read and write requests.
REQ-008 Port cpu_rdata  output  32  is the registered read data.
REQ-009 Port cpu_stall  output  1  freezes the datapath while an access is open.
REQ-010 Port mem_req  output  1  is the request to the handshake memory.
REQ-011 Port mem_we  output  1  marks the request as a write.
REQ-012 Port mem_addr  output  ADDR_W  carries cpu_adr[ADDR_W+1:2].
REQ-013 Port mem_wdata  output  32  carries the captured store data.
REQ-014 Port mem_ack  input  1  completes the request.
REQ-015 Port mem_rdata  input  32  is valid with mem_ack.
REQ-016 Port err  output  1  is a sticky timeout flag.

Function
REQ-017 The FSM SHALL have states IDLE, WAIT and DONE.
REQ-018 In IDLE with cpu_re|cpu_we, the block SHALL register address, wdata and we (we = cpu_we; write wins if both are set) and go to WAIT.
REQ-019 cpu_stall SHALL be combinational: 1 in IDLE with a request pending, 1 in WAIT, 0 in DONE and in idle IDLE.
REQ-020 In WAIT, mem_req SHALL be 1, and mem_addr/mem_we/mem_wdata SHALL stay constant until mem_ack.
REQ-021 On mem_ack in WAIT: mem_req SHALL drop next cycle, reads SHALL load mem_rdata into cpu_rdata, and the FSM SHALL go to DONE.
REQ-022 Writes SHALL leave cpu_rdata unchanged.
REQ-023 DONE SHALL last exactly one cycle with cpu_stall 0, then return to IDLE whatever the request inputs are.
REQ-024 Minimum latency: request in cycle 0, ack in cycle 1, data valid and stall released in cycle 2.
REQ-025 mem_ack in IDLE or DONE SHALL be ignored.
REQ-026 Request inputs SHALL be ignored outside IDLE.
REQ-027 Reset mid-access SHALL abandon the access at once with no memory side effect beyond what was already acked.

Reset
REQ-028 While rst_n is 0: state IDLE, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, cpu_rdata 0, err 0, and the timeout counter 0.
REQ-029 Leaving reset SHALL take effect on the first rising clk edge after rst_n rises.

Configuration
REQ-030 Macro MEM_TIMEOUT_EN defined: a counter SHALL clear on entering WAIT and count each WAIT cycle without ack.
REQ-031 At TIMEOUT_CYC cycles without ack, the FSM SHALL go to DONE, drop mem_req, load cpu_rdata with 32'hDEADBEEF on reads, and set err.
REQ-032 err SHALL stay set until reset; an ack in the same cycle as expiry wins.
REQ-033 Macro MEM_TIMEOUT_EN undefined: there SHALL be no counter, WAIT SHALL wait forever, and err SHALL be tied to 0.

Structure
REQ-034 Package mem_wait_pkg SHALL hold the state enum, the constant MEM_ABORT_DATA = 32'hDEADBEEF and the default TIMEOUT_CYC.
REQ-035 The counter SHALL be a sub-module mem_wd_cnt (inputs clr, en; output expired), instantiated only under MEM_TIMEOUT_EN.

Verification
REQ-036 Read of cpu_adr 0x10 with ack in the first WAIT cycle and mem_rdata 0x12345678: mem_addr = 4, stall for 2 cycles, cpu_rdata = 0x12345678 in cycle 2.
REQ-037 Write to 0x20 with data 0xCAFE0001 and ack after 5 WAIT cycles: mem_we = 1, mem_addr = 8, data held stable, stall for 6 cycles, cpu_rdata unchanged.
REQ-038 cpu_re and cpu_we both set: mem_we = 1; and a stray mem_ack in IDLE causes no state change.
REQ-039 With MEM_TIMEOUT_EN and no ack: after 16 WAIT cycles, mem_req drops, cpu_rdata = 0xDEADBEEF, err = 1; err stays 1 through a following good access.
REQ-040 rst_n pulled low during WAIT: mem_req is 0 and state is IDLE in the same cycle, err = 0, and a fresh read after reset completes normally.
